// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that owns the select of a shared N-to-1, 1-bit mux and
// registers the selected bit. A hold counter limits tenure while others wait.
module rr_mux_arbiter #(
  parameter int N        = 4,
  parameter int LOGN     = $clog2(N),
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    I,
  output logic [N-1:0]    grant,
  output logic [LOGN-1:0] S,
  output logic            outMux,
  output logic            busy
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  typedef struct packed {
    logic            found;
    logic [LOGN-1:0] idx;
  } pick_t;

  // First requester at or after start, wrapping modulo N (not 2^LOGN).
  function automatic pick_t f_pick(input logic [N-1:0] r, input logic [LOGN-1:0] start);
    pick_t p;
    int    idx;
    p = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (!p.found && r[idx]) begin
        p.found = 1'b1;
        p.idx   = LOGN'(idx);
      end
    end
    return p;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_grant, w_grant_nxt;
  logic [LOGN-1:0] r_S, w_S_nxt;
  logic            r_out, w_out_nxt;
  logic            r_busy, w_busy_nxt;
  logic [LOGN-1:0] r_ptr, w_ptr_nxt;
  logic [HW-1:0]   r_hold, w_hold_nxt;

  logic [LOGN-1:0] w_after_owner;
  logic            w_others;
  logic            w_release;
  pick_t           w_idle_pick;
  pick_t           w_rel_pick;

  assign w_after_owner = (r_S == LOGN'(N-1)) ? '0 : r_S + 1'b1;
  assign w_others      = |(req & ~r_grant);
  assign w_release     = !req[r_S] || ((r_hold == HW'(MAX_HOLD)) && w_others);
  assign w_idle_pick   = f_pick(req, r_ptr);
  // The owner is masked out on release: under (a) its req is already low,
  // under (b) it must not win its own handover.
  assign w_rel_pick    = f_pick(req & ~r_grant, w_after_owner);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_S_nxt     = r_S;
    w_out_nxt   = r_out;
    w_busy_nxt  = r_busy;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_IDLE: begin
        w_out_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_grant_nxt = '0;
        if (w_idle_pick.found) begin
          w_grant_nxt = {{(N-1){1'b0}}, 1'b1} << w_idle_pick.idx;
          w_S_nxt     = w_idle_pick.idx;
          w_busy_nxt  = 1'b1;
          w_hold_nxt  = HW'(1);
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_out_nxt = I[r_S];
        if (w_release) begin
          w_ptr_nxt = w_after_owner;
          if (w_rel_pick.found) begin
            w_grant_nxt = {{(N-1){1'b0}}, 1'b1} << w_rel_pick.idx;
            w_S_nxt     = w_rel_pick.idx;
            w_hold_nxt  = HW'(1);
          end else begin
            w_grant_nxt = '0;
            w_busy_nxt  = 1'b0;
            w_out_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end else if (r_hold != HW'(MAX_HOLD)) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_S     <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_S     <= w_S_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= w_busy_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign grant  = r_grant;
  assign S      = r_S;
  assign outMux = r_out;
  assign busy   = r_busy;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: an N=4 instance for the main plan and an
// N=3 instance for modulo-N wrap, plus per-cycle invariant checks.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req4, I4, grant4;
  logic [1:0] S4;
  logic       out4, busy4;
  logic [2:0] req3, I3, grant3;
  logic [1:0] S3;
  logic       out3, busy3;

  int n_tests = 0;
  int n_fail  = 0;

  rr_mux_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req4), .I(I4),
    .grant(grant4), .S(S4), .outMux(out4), .busy(busy4)
  );

  rr_mux_arbiter #(.N(3), .MAX_HOLD(8)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .I(I3),
    .grant(grant3), .S(S3), .outMux(out3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Invariants: one-hot-or-zero grant, grant[S]==busy, S < N.
  always @(negedge clk) begin
    if (!reset) begin
      chk("inv_onehot4", {31'b0, $onehot0(grant4)}, 32'd1);
      chk("inv_gs4", {31'b0, grant4[S4]}, {31'b0, busy4});
      chk("inv_onehot3", {31'b0, $onehot0(grant3)}, 32'd1);
      chk("inv_s3", {31'b0, S3 != 2'd3}, 32'd1);
    end
  end

  initial begin
    reset = 1'b1;
    req4 = '0; I4 = '0; req3 = '0; I3 = '0;
    tick(2);
    chk("rst_grant", grant4, 0);
    chk("rst_S", S4, 0);
    chk("rst_out", out4, 0);
    chk("rst_busy", busy4, 0);
    reset = 1'b0;

    // Mid-grant reset
    req4 = 4'b1111; I4 = 4'b1111;
    tick(1);
    chk("first_grant", grant4, 4'b0001);
    chk("first_busy", busy4, 1);
    chk("first_out", out4, 0);
    tick(9);
    chk("pre_rst_grant", grant4, 4'b0010);
    chk("pre_rst_S", S4, 1);
    chk("pre_rst_out", out4, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_grant", grant4, 0);
    chk("async_S", S4, 0);
    chk("async_out", out4, 0);
    chk("async_busy", busy4, 0);
    reset = 1'b0;
    tick(1);
    chk("post_rst_grant", grant4, 4'b0001);
    req4 = 4'b0000;
    tick(1);
    chk("drop_grant", grant4, 0);
    chk("drop_busy", busy4, 0);
    chk("drop_out", out4, 0);

    // Single requester 2, data follows one edge later
    I4 = 4'b0000; req4 = 4'b0100;
    tick(1);
    chk("single_grant", grant4, 4'b0100);
    chk("single_S", S4, 2);
    chk("single_out0", out4, 0);
    I4 = 4'b0100; tick(1);
    chk("single_out1", out4, 1);
    I4 = 4'b0000; tick(1);
    chk("single_out2", out4, 0);
    I4 = 4'b0100; tick(1);
    chk("single_out3", out4, 1);
    req4 = 4'b0000; tick(1);
    chk("single_rel_grant", grant4, 0);
    chk("single_rel_busy", busy4, 0);
    chk("single_rel_out", out4, 0);

    // Fairness: 0,1,2,3,0 each exactly 8 cycles, no bubble
    reset = 1'b1; #1 reset = 1'b0;
    I4 = 4'b0000; req4 = 4'b1111;
    tick(1);
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 8; c++) begin
        chk($sformatf("fair_o%0d_c%0d", o, c), grant4, 32'd1 << (o % 4));
        chk($sformatf("fair_busy_o%0d_c%0d", o, c), busy4, 1);
        tick(1);
      end
    end
    chk("fair_next", grant4, 4'b0010);

    // Early release of owner 1 to 3, then 3 yields to 0 ahead of 1
    req4 = 4'b1010; tick(2);
    chk("early_hold", grant4, 4'b0010);
    req4 = 4'b1000; tick(1);
    chk("early_grant", grant4, 4'b1000);
    chk("early_S", S4, 3);
    req4 = 4'b1011; tick(7);
    chk("early_hold_restart", grant4, 4'b1000);
    tick(1);
    chk("early_ptr", grant4, 4'b0001);
    req4 = 4'b0000; tick(1);
    chk("early_idle", busy4, 0);

    // Lone hog keeps grant, yields once another requester appears
    req4 = 4'b0001; tick(1);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("hog_c%0d", c), grant4, 4'b0001);
      tick(1);
    end
    req4 = 4'b0101; tick(1);
    chk("hog_yield", grant4, 4'b0100);
    chk("hog_yield_S", S4, 2);
    req4 = 4'b0000; tick(1);

    // N=3: owner 2 releases, wrap lands on 0
    req3 = 3'b111; tick(1);
    chk("n3_first", grant3, 3'b001);
    tick(16);
    chk("n3_owner2", grant3, 3'b100);
    chk("n3_S2", S3, 2);
    tick(8);
    chk("n3_wrap", grant3, 3'b001);
    chk("n3_wrap_S", S3, 0);
    req3 = 3'b000; tick(1);
    chk("n3_idle", busy3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 2^n-to-1, 1-bit multiplexer datapath.
- N requesters each present a request line and a 1-bit data line. The block grants one requester at a time and drives the internal mux select to that requester.
- It registers the selected data bit onto a single shared output.
- A hold counter bounds tenure so no requester starves the others.
- Sits between independent 1-bit sources and a single shared serial sink.

Parameters:
- N, 4, number of requesters / mux inputs (N >= 2; need not be a power of two).
- LOGN, $clog2(N), select width.
- MAX_HOLD, 8, maximum consecutive granted cycles while another requester is waiting (>= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  request lines; req[i] high = requester i wants the channel.
- I  input  N  data bits; I[i] belongs to requester i.
- grant  output  N  registered one-hot grant (all-zero when idle).
- S  output  LOGN  registered mux select = index of current owner (holds last owner when idle).
- outMux  output  1  registered shared data = I[S] sampled while granted, 0 when idle.
- busy  output  1  registered; high while any grant is active.

Behaviour:
- Reset (async, immediate):
  - grant=0, S=0, outMux=0, busy=0.
  - State IDLE, priority pointer ptr=0, holdCnt=0.
  - Reset mid-grant drops the grant in the same instant; there is no completion of tenure.
- Eligible search:
  - The winner is the first i with req[i]=1, scanning from the start index upward with wrap at N-1 -> 0.
  - The start index is ptr in IDLE, or owner+1 mod N on release.
  - Indices >= N never exist; wrap is modulo N, not 2^LOGN.
- State IDLE:
  - busy=0, grant=0, outMux<=0.
  - At an edge with any req high: load grant=onehot(winner), S=winner, busy=1, holdCnt=1, go GRANT.
  - Latency: req high at edge k -> grant/S/busy visible after edge k (one cycle).
- State GRANT (owner = S):
  - Each edge: outMux <= I[S]. First valid data appears one edge after grant asserts.
- Release condition, evaluated at each edge:
  - (a) req[owner]=0, or
  - (b) holdCnt==MAX_HOLD and some other req[j]=1 (j != owner).
- On release:
  - ptr <= owner+1 mod N.
  - If another requester (excluding owner under (b); any under (a)) is eligible, hand over in the same edge: new grant/S, holdCnt=1, stay GRANT (no idle bubble).
  - Otherwise go IDLE: grant=0, busy=0, outMux<=0.
- No release:
  - holdCnt <= holdCnt+1, saturating at MAX_HOLD.
  - If the owner is alone at MAX_HOLD, it keeps the grant indefinitely.
- Simultaneous events:
  - Owner drops req in the same cycle others raise req: handover per (a).
  - Owner re-raises req after release: it waits its round-robin turn.
- Invariants:
  - grant is always one-hot or zero.
  - grant[S]==busy.
  - S never >= N.
- holdCnt width: $clog2(MAX_HOLD+1).

Test Plan:
- Reset: assert reset mid-grant with req=4'b1111 -> grant=0, busy=0, outMux=0, S=0 immediately; after deassert, first grant goes to requester 0.
- Single requester: req=4'b0100 at edge k -> grant=4'b0100, S=2 after edge k; toggle I[2] 1,0,1 -> outMux follows one edge later; drop req -> grant=0, busy=0 next edge.
- Fairness with N=4, MAX_HOLD=8, req=4'b1111 held -> grants 0,1,2,3,0, each lasting exactly 8 cycles, back-to-back with no idle cycle.
- Early release: owner 1 drops req after 3 cycles while req[3]=1 -> same edge grant moves to 3, holdCnt restarts; ptr then favours 0 over 1.
- Lone hog: only req[0]=1 for 20 cycles -> grant stays 4'b0001 throughout; raise req[2] at cycle 20 -> grant moves to 2 at the next edge.
- Non-power-of-two N=3: req=3'b111 with owner 2 releasing -> next grant is 0 (wrap modulo 3); S never equals 3.
